fire4_squeeze_ofm_buffer: RTL

Downstream neighbour of the fire4 squeeze stage: captures the 32-channel output vector it presents on every sample pulse and drains it serially into an on-chip feature-map RAM at address pixel·DSP_NO + channel. After WOUT² pixels it returns the `ram_feedback` pulse to the squeeze stage and serves random-access reads to the fire4 expand stages.

---
 rtl/fire4_pkg.sv | 34 +++
 rtl/fire4_buf_ram.sv | 33 +++
 rtl/fire4_squeeze_ofm_buffer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/fire4_pkg.sv
// ---------------------------------------------------------------------------
// fire4_pkg
// Shared constants and types for the fire4 squeeze output feature-map buffer.
//   WIDTH  : activation word width
//   DSP_NO : channels per sample vector
//   WOUT   : output map side, a frame holds NPIX = WOUT*WOUT pixels
//   DEPTH  : RAM words (NPIX*DSP_NO), AW address bits
//   RAW    : read address width; one bit wider than AW so that addresses at
//            or beyond DEPTH can be presented and answered with zero
// ---------------------------------------------------------------------------
package fire4_pkg;

  localparam int WIDTH  = 16;
  localparam int DSP_NO = 32;
  localparam int WOUT   = 32;
  localparam int NPIX   = WOUT * WOUT;
  localparam int DEPTH  = NPIX * DSP_NO;
  localparam int AW     = $clog2(DEPTH);
  localparam int RAW    = AW + 1;
  localparam int CW     = $clog2(DSP_NO);
  localparam int PW     = $clog2(NPIX) + 1;

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} buf_state_t;
  typedef logic [WIDTH-1:0] act_t;

  // Word address of channel ch of pixel pix, truncated to the RAM address width.
  function automatic logic [AW-1:0] wr_addr(input logic [PW-1:0] pix,
                                            input logic [CW-1:0] ch);
    logic [31:0] full;
    full = 32'(pix) * 32'(DSP_NO) + 32'(ch);
    return full[AW-1:0];
  endfunction

endpackage

// File: rtl/fire4_buf_ram.sv
// ---------------------------------------------------------------------------
// fire4_buf_ram
// Simple dual-port RAM, DEPTH x WIDTH: one write port and one registered read
// port. The array has no reset so it maps onto block RAM.
//   clk   : clock
//   we    : write enable, waddr/wdata : write address and data
//   re    : read enable,  raddr       : read address
//   rdata : registered read data, holds its value while re is low
// ---------------------------------------------------------------------------
module fire4_buf_ram
  import fire4_pkg::*;
(
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  act_t          wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output act_t          rdata
);

  act_t mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fire4_squeeze_ofm_buffer.sv
// ---------------------------------------------------------------------------
// fire4_squeeze_ofm_buffer
// Captures each 32-channel vector from the fire4 squeeze stage and drains it
// one word per cycle into the feature-map RAM at pixel*DSP_NO + channel.
// After NPIX pixels the frame is complete: ram_feedback pulses once, done
// rises and random-access reads are served to the expand stages.
//   clk          : rising-edge clock
//   rst          : asynchronous active-low reset
//   clear        : synchronous frame restart (RAM contents kept)
//   sample_in    : one-cycle strobe, ofm_in valid
//   ofm_in       : channel vector [0:DSP_NO-1]
//   ram_feedback : one-cycle pulse on frame completion
//   done         : frame stored, reads permitted
//   rd_en/rd_addr: read request and word address
//   rd_data      : read word (1-cycle latency), holds when no read accepted
//   rd_valid     : one-cycle echo of an accepted read
//   overrun      : sticky, a sample arrived while draining
// Build option: FIRE4_BUF_OVERRUN_DET_EN enables overrun detection; without
// it overrun is tied low and samples during DRAIN are dropped silently.
// ---------------------------------------------------------------------------
module fire4_squeeze_ofm_buffer
  import fire4_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           sample_in,
  input  act_t           ofm_in [0:DSP_NO-1],
  output logic           ram_feedback,
  output logic           done,
  input  logic           rd_en,
  input  logic [RAW-1:0] rd_addr,
  output act_t           rd_data,
  output logic           rd_valid,
  output logic           overrun
);

  buf_state_t      state;
  logic [PW-1:0]   pix_cnt;
  logic [CW-1:0]   ch_cnt;
  act_t            shadow [0:DSP_NO-1];
  act_t            ram_q;
  logic            rd_zero;
  logic            rd_accept;
  logic            rd_oor;
  logic            wr_en;
  logic [AW-1:0]   wr_address;
  logic [PW-1:0]   pix_next;

  assign pix_next   = pix_cnt + 1'b1;
  assign wr_en      = (state == DRAIN);
  assign wr_address = wr_addr(pix_cnt, ch_cnt);
  assign rd_accept  = rd_en & done;
  assign rd_oor     = (rd_addr >= RAW'(DEPTH));

  // Shadow copy of the incoming vector; loaded only when the FSM accepts it.
  always_ff @(posedge clk) begin
    if (state == IDLE && sample_in && !clear) begin
      shadow <= ofm_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      pix_cnt      <= '0;
      ch_cnt       <= '0;
      done         <= 1'b0;
      ram_feedback <= 1'b0;
    end else begin
      ram_feedback <= 1'b0;
      if (clear) begin
        state   <= IDLE;
        pix_cnt <= '0;
        ch_cnt  <= '0;
        done    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (sample_in) begin
              ch_cnt <= '0;
              state  <= DRAIN;
            end
          end
          DRAIN: begin
            if (ch_cnt == CW'(DSP_NO - 1)) begin
              ch_cnt  <= '0;
              pix_cnt <= pix_next;
              if (pix_next == PW'(NPIX)) begin
                state        <= DONE;
                done         <= 1'b1;
                ram_feedback <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end else begin
              ch_cnt <= ch_cnt + 1'b1;
            end
          end
          DONE: begin
            done <= 1'b1;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef FIRE4_BUF_OVERRUN_DET_EN
  // Sticky flag: a sample strobe while draining means upstream spacing broke.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun <= 1'b0;
    end else if (clear) begin
      overrun <= 1'b0;
    end else if (state == DRAIN && sample_in) begin
      overrun <= 1'b1;
    end
  end
`else
  assign overrun = 1'b0;
`endif

  // rd_zero selects a zero word after reset or after an out-of-range read;
  // it only changes on accepted reads so rd_data holds otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_zero  <= 1'b1;
    end else begin
      rd_valid <= rd_accept;
      if (rd_accept) begin
        rd_zero <= rd_oor;
      end
    end
  end

  assign rd_data = rd_zero ? '0 : ram_q;

  fire4_buf_ram u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_address),
    .wdata (shadow[ch_cnt]),
    .re    (rd_accept & ~rd_oor),
    .raddr (rd_addr[AW-1:0]),
    .rdata (ram_q)
  );

endmodule
